// File: rtl/lsu_if.sv
// Core-request, response and word-memory signals of the load/store unit.
// The slave modport is the unit itself; the master side is the core plus the memory.
interface lsu_if #(
  parameter int unsigned Width = 32
) ();

  logic             req_valid;
  logic             req_ready;
  logic             req_we;
  logic [1:0]       req_size;
  logic             req_unsigned;
  logic [Width-1:0] req_addr;
  logic [Width-1:0] req_wdata;

  logic             resp_valid;
  logic [Width-1:0] resp_rdata;
  logic             resp_err;

  logic [Width-1:0] mem_addr;
  logic             mem_we;
  logic [Width-1:0] mem_wdata;
  logic [Width-1:0] mem_rdata;

  modport slave (
    input  req_valid,
    input  req_we,
    input  req_size,
    input  req_unsigned,
    input  req_addr,
    input  req_wdata,
    input  mem_rdata,
    output req_ready,
    output resp_valid,
    output resp_rdata,
    output resp_err,
    output mem_addr,
    output mem_we,
    output mem_wdata
  );

  modport master (
    output req_valid,
    output req_we,
    output req_size,
    output req_unsigned,
    output req_addr,
    output req_wdata,
    output mem_rdata,
    input  req_ready,
    input  resp_valid,
    input  resp_rdata,
    input  resp_err,
    input  mem_addr,
    input  mem_we,
    input  mem_wdata
  );

endinterface

// File: rtl/lsu.sv
// Load/store unit: byte/half/word accesses on a word-addressed memory, with
// alignment checking, read-modify-write for sub-word stores and load extension.
module lsu #(
  parameter int unsigned Width = 32
) (
  input  logic  clk_i,
  input  logic  rst_i,
  lsu_if.slave  bus_io
);

  typedef enum logic [1:0] {StIdle, StRead, StWrite, StDone} state_e;

  state_e           state_q, state_d;
  logic [Width-1:0] addr_q, addr_d;
  logic [Width-1:0] wdata_q, wdata_d;
  logic [Width-1:0] rdata_q, rdata_d;
  logic [1:0]       size_q, size_d;
  logic             uns_q, uns_d;
  logic             we_q, we_d;
  logic             err_q, err_d;

  logic             req_bad;
  logic [7:0]       rd_byte;
  logic [15:0]      rd_half;
  logic             ext_bit;
  logic [Width-1:0] load_ext;
  logic [Width-1:0] merged;

  always_comb begin
    req_bad = 1'b0;
    unique case (bus_io.req_size)
      2'b00:   req_bad = 1'b0;
      2'b01:   req_bad = bus_io.req_addr[0];
      2'b10:   req_bad = (bus_io.req_addr[1:0] != 2'b00);
      default: req_bad = 1'b1;
    endcase
  end

  // Lane extraction from the memory word at the latched address.
  always_comb begin
    rd_byte = bus_io.mem_rdata[7:0];
    unique case (addr_q[1:0])
      2'b00:   rd_byte = bus_io.mem_rdata[7:0];
      2'b01:   rd_byte = bus_io.mem_rdata[15:8];
      2'b10:   rd_byte = bus_io.mem_rdata[23:16];
      default: rd_byte = bus_io.mem_rdata[31:24];
    endcase
    rd_half = addr_q[1] ? bus_io.mem_rdata[31:16] : bus_io.mem_rdata[15:0];
  end

  always_comb begin
    load_ext = bus_io.mem_rdata;
    ext_bit  = 1'b0;
    unique case (size_q)
      2'b00: begin
        ext_bit  = ~uns_q & rd_byte[7];
        load_ext = {{(Width-8){ext_bit}}, rd_byte};
      end
      2'b01: begin
        ext_bit  = ~uns_q & rd_half[15];
        load_ext = {{(Width-16){ext_bit}}, rd_half};
      end
      default: load_ext = bus_io.mem_rdata;
    endcase
  end

  // Sub-word store: only the addressed lane takes store data.
  always_comb begin
    merged = bus_io.mem_rdata;
    if (size_q == 2'b00) begin
      unique case (addr_q[1:0])
        2'b00:   merged[7:0]   = wdata_q[7:0];
        2'b01:   merged[15:8]  = wdata_q[7:0];
        2'b10:   merged[23:16] = wdata_q[7:0];
        default: merged[31:24] = wdata_q[7:0];
      endcase
    end else if (size_q == 2'b01) begin
      if (addr_q[1]) begin
        merged[31:16] = wdata_q[15:0];
      end else begin
        merged[15:0] = wdata_q[15:0];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    size_d  = size_q;
    uns_d   = uns_q;
    we_d    = we_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (bus_io.req_valid) begin
          addr_d  = bus_io.req_addr;
          wdata_d = bus_io.req_wdata;
          size_d  = bus_io.req_size;
          uns_d   = bus_io.req_unsigned;
          we_d    = bus_io.req_we;
          err_d   = req_bad;
          rdata_d = '0;
          if (req_bad) begin
            state_d = StDone;
          end else if (bus_io.req_we && (bus_io.req_size == 2'b10)) begin
            state_d = StWrite;
          end else begin
            state_d = StRead;
          end
        end
      end
      StRead: begin
        if (we_q) begin
          wdata_d = merged;
          state_d = StWrite;
        end else begin
          rdata_d = load_ext;
          state_d = StDone;
        end
      end
      StWrite: state_d = StDone;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      we_q    <= we_d;
      err_q   <= err_d;
    end
  end

  // Outputs decode from state only, so reset drops mem_we without waiting for a clock.
  always_comb begin
    bus_io.req_ready  = (state_q == StIdle);
    bus_io.resp_valid = (state_q == StDone);
    bus_io.resp_rdata = (state_q == StDone) ? rdata_q : '0;
    bus_io.resp_err   = (state_q == StDone) & err_q;
    bus_io.mem_addr   = {addr_q[Width-1:2], 2'b00};
    bus_io.mem_we     = (state_q == StWrite);
    bus_io.mem_wdata  = (state_q == StWrite) ? wdata_q : '0;
  end

endmodule

// File: tb/tb_lsu.sv
// Bench for lsu: directed cases, reset during a write, a held request, then
// random transactions against a word-array reference model.
module tb_lsu;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic preload = 1'b1;

  lsu_if #(.Width(32)) bus ();

  lsu #(.Width(32)) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .bus_io (bus)
  );

  logic [31:0] mem     [64];
  logic [31:0] ref_mem [64];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign bus.mem_rdata = mem[bus.mem_addr[7:2]];

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 64; i++) mem[i] <= ref_mem[i];
    end else if (bus.mem_we) begin
      mem[bus.mem_addr[7:2]] <= bus.mem_wdata;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic run_txn(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output logic [31:0] obs_rdata);
    logic [31:0] w, v, mask, e_rdata, e_wdata, obs_wdata;
    logic        e_err, obs_err;
    int          widx, sh, e_lat, e_wecyc, lat, nresp, nwe, wecyc, n;
    widx    = int'(addr[7:2]);
    sh      = 8 * int'(addr[1:0]);
    w       = ref_mem[widx];
    e_err   = (size == 2'b11) || (size == 2'b01 && addr[0]) ||
              (size == 2'b10 && addr[1:0] != 2'b00);
    e_rdata = 0;
    e_wdata = 0;
    e_wecyc = 0;
    e_lat   = 2;
    if (e_err) begin
      e_lat = 1;
    end else if (!we) begin
      if (size == 2'b00) begin
        v = (w >> sh) & 32'hFF;
        if (!uns && v > 32'h7F) v = v | 32'hFFFFFF00;
      end else if (size == 2'b01) begin
        v = (w >> sh) & 32'hFFFF;
        if (!uns && v > 32'h7FFF) v = v | 32'hFFFF0000;
      end else begin
        v = w;
      end
      e_rdata = v;
    end else if (size == 2'b10) begin
      e_wecyc = 1;
      e_wdata = wdata;
    end else begin
      e_lat   = 3;
      e_wecyc = 2;
      mask    = ((size == 2'b00) ? 32'hFF : 32'hFFFF) << sh;
      e_wdata = (w & ~mask) | ((wdata << sh) & mask);
    end
    if (e_wecyc != 0) ref_mem[widx] = e_wdata;

    @(negedge clk);
    bus.req_valid    = 1'b1;
    bus.req_we       = we;
    bus.req_size     = size;
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wdata;
    n = 0;
    while (!bus.req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("accept_ready", 32'(bus.req_ready), 32'd1);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;

    lat = 0; nresp = 0; nwe = 0; wecyc = 0;
    obs_rdata = 0; obs_err = 0; obs_wdata = 0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (bus.resp_valid) begin
        nresp++;
        if (lat == 0) begin
          lat       = c;
          obs_rdata = bus.resp_rdata;
          obs_err   = bus.resp_err;
        end
      end
      if (bus.mem_we) begin
        nwe++;
        wecyc     = c;
        obs_wdata = bus.mem_wdata;
      end
    end
    chk("resp_cycle", 32'(lat), 32'(e_lat));
    chk("resp_pulses", 32'(nresp), 32'd1);
    chk("resp_rdata", obs_rdata, e_rdata);
    chk("resp_err", 32'(obs_err), 32'(e_err));
    chk("mem_we_count", 32'(nwe), (e_wecyc != 0) ? 32'd1 : 32'd0);
    chk("mem_we_cycle", 32'(wecyc), 32'(e_wecyc));
    chk("mem_wdata", obs_wdata, e_wdata);
  endtask

  initial begin
    logic [31:0] r;
    int          nresp;
    bus.req_valid    = 1'b0;
    bus.req_we       = 1'b0;
    bus.req_size     = 2'b00;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = 32'h0;
    bus.req_wdata    = 32'h0;
    for (int i = 0; i < 64; i++) ref_mem[i] = $urandom;
    ref_mem[4] = 32'h8899AABB;

    repeat (2) @(posedge clk);
    @(negedge clk);
    preload = 1'b0;
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_resp_rdata", bus.resp_rdata, 32'h0);
    chk("rst_resp_err", 32'(bus.resp_err), 32'd0);
    chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'h0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'h0);
    rst = 1'b0;

    run_txn(1'b0, 2'b00, 1'b0, 32'h12, 32'h0, r);
    chk("lb_signed", r, 32'hFFFFFF99);
    run_txn(1'b0, 2'b00, 1'b1, 32'h12, 32'h0, r);
    chk("lbu", r, 32'h00000099);
    run_txn(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, r);
    chk("lh_signed", r, 32'hFFFF8899);
    run_txn(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, r);
    chk("lw", r, 32'h8899AABB);
    run_txn(1'b1, 2'b00, 1'b0, 32'h11, 32'hFFFFFF5A, r);
    run_txn(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, r);
    chk("sb_readback", r, 32'h88995ABB);
    run_txn(1'b1, 2'b10, 1'b0, 32'h20, 32'hDEADBEEF, r);
    run_txn(1'b1, 2'b01, 1'b0, 32'h22, 32'h00001234, r);
    run_txn(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, r);
    chk("sh_readback", r, 32'h1234BEEF);
    run_txn(1'b0, 2'b10, 1'b0, 32'h21, 32'h0, r);
    run_txn(1'b1, 2'b01, 1'b0, 32'h13, 32'hFFFF, r);
    run_txn(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, r);

    // Reset during the WRITE cycle of a byte store: nothing may be written.
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_size  = 2'b00;
    bus.req_addr  = 32'h31;
    bus.req_wdata = 32'h77;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    chk("rst_txn_read_we", 32'(bus.mem_we), 32'd0);
    @(negedge clk);
    chk("rst_txn_write_we", 32'(bus.mem_we), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_async_we", 32'(bus.mem_we), 32'd0);
    chk("rst_async_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_async_resp", 32'(bus.resp_valid), 32'd0);
    @(negedge clk);
    rst   = 1'b0;
    nresp = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (bus.resp_valid) nresp++;
    end
    chk("rst_no_resp", 32'(nresp), 32'd0);
    chk("rst_word_kept", mem[12], ref_mem[12]);

    // Request held during a busy load is taken only once the unit is idle again.
    @(negedge clk);
    bus.req_valid    = 1'b1;
    bus.req_we       = 1'b0;
    bus.req_size     = 2'b10;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = 32'h10;
    @(posedge clk);
    #1;
    bus.req_size     = 2'b00;
    bus.req_unsigned = 1'b1;
    bus.req_addr     = 32'h13;
    @(negedge clk);
    chk("held_c1_ready", 32'(bus.req_ready), 32'd0);
    chk("held_c1_resp", 32'(bus.resp_valid), 32'd0);
    @(negedge clk);
    chk("held_c2_ready", 32'(bus.req_ready), 32'd0);
    chk("held_c2_resp", 32'(bus.resp_valid), 32'd1);
    chk("held_a_rdata", bus.resp_rdata, ref_mem[4]);
    @(negedge clk);
    chk("held_c3_ready", 32'(bus.req_ready), 32'd1);
    chk("held_c3_resp", 32'(bus.resp_valid), 32'd0);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    chk("held_b_c1_ready", 32'(bus.req_ready), 32'd0);
    @(negedge clk);
    chk("held_b_resp", 32'(bus.resp_valid), 32'd1);
    chk("held_b_rdata", bus.resp_rdata, (ref_mem[4] >> 24) & 32'hFF);

    for (int t = 0; t < 200; t++) begin
      logic [1:0] sz;
      sz = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      run_txn(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)),
              32'($urandom_range(0, 255)), $urandom, r);
    end

    @(negedge clk);
    for (int i = 0; i < 64; i++) chk("final_mem", mem[i], ref_mem[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit sitting between the core's memory stage and the word-addressed data memory. Accepts byte, halfword and word loads/stores from the core, checks alignment, and issues word-wide accesses on the memory side. Sub-word stores become read-modify-write sequences. Load data is extracted by byte lane and sign- or zero-extended before being returned with a one-cycle response strobe.

## Interface
- n, 32, data/address width; byte-lane logic is defined only for n = 32
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- req_valid  input  1  core request present
- req_ready  output  1  unit idle, request accepted this cycle if req_valid
- req_we  input  1  1 = store, 0 = load
- req_size  input  2  00 byte, 01 half, 10 word, 11 illegal
- req_unsigned  input  1  loads: 1 = zero-extend, 0 = sign-extend
- req_addr  input  n  byte address
- req_wdata  input  n  store data, right-justified
- resp_valid  output  1  one-cycle pulse: transaction complete
- resp_rdata  output  n  extended load data; 0 for stores and errors
- resp_err  output  1  misaligned or illegal-size request; valid with resp_valid
- mem_addr  output  n  word address to memory, bits [1:0] always 0
- mem_we  output  1  memory write enable
- mem_wdata  output  n  memory write data
- mem_rdata  input  n  memory read data, combinational from mem_addr

## Operation
- States: IDLE, READ, WRITE, DONE. req_ready = 1 only in IDLE.
- IDLE, req_valid = 1: latch addr, wdata, size, unsigned, we at the edge. Next state:
  - misaligned (half with addr[0] = 1, word with addr[1:0] != 0) or size 11 -> DONE with err = 1, no memory access
  - load or byte/half store -> READ
  - word store -> WRITE
- READ: mem_addr = {addr_q[n-1:2], 2'b00}, mem_we = 0. At the edge, mem_rdata is captured. Load -> DONE with extracted data. Sub-word store -> WRITE with the merged word.
- WRITE: mem_we = 1. mem_wdata = wdata_q (word store) or the merged word. -> DONE.
- DONE: resp_valid = 1 for exactly one cycle, resp_rdata and resp_err valid. -> IDLE.
- Byte lanes are little-endian:
  - byte k = addr[1:0] occupies bits [8k+7:8k]
  - half at addr[1] = 0 occupies [15:0]; at addr[1] = 1 it occupies [31:16]
- Merge replaces only the addressed lane with wdata_q[7:0] or [15:0]; all other bits keep the read value.
- Load extension: bit 7 (byte) or bit 15 (half) of the extracted lane replicates upward when unsigned = 0; zeros otherwise. Word loads pass through unchanged.
- mem_addr holds the latched address in all states. mem_we is 0 outside WRITE. mem_wdata is 0 outside WRITE.
- req_valid outside IDLE is ignored; the core holds the request until it sees req_ready.

## Timing
- The accept edge is cycle 0. resp_valid is high in:
  - cycle 2 for loads and word stores
  - cycle 3 for sub-word stores
  - cycle 1 for errors
- The memory write occurs at the rising edge that ends the WRITE cycle.
- Back-to-back throughput: a new request can be accepted in the cycle after DONE (IDLE).
- Reset values: state IDLE, req_ready 1, resp_valid 0, resp_rdata 0, resp_err 0, mem_we 0, mem_addr 0, mem_wdata 0. All latched registers are 0.
- Reset asserted mid-transaction:
  - immediately (asynchronously) forces IDLE and drops mem_we
  - an in-flight store therefore never writes
  - no resp_valid is issued for the dropped request

## Test plan
- Mem word 0x10 = 0x8899AABB; load byte signed at 0x12 -> resp_rdata 0xFFFFFF99 in cycle 2, err 0. Unsigned at the same address -> 0x00000099.
- Same word; load half signed at 0x12 -> 0xFFFF8899. Load word at 0x10 -> 0x8899AABB.
- Store byte 0x5A to 0x11 over 0x8899AABB -> READ then WRITE. mem_wdata 0x88995ABB with mem_we high in cycle 2, resp_valid in cycle 3. A readback word load returns 0x88995ABB.
- Store word 0xDEADBEEF to 0x20 -> mem_we only in cycle 1, no READ state, resp_valid in cycle 2. A half store of 0x1234 to 0x22 then yields 0x1234BEEF.
- Misaligned word load at 0x21, half store at 0x13, and size 11 -> resp_err 1 and resp_rdata 0 in cycle 1, mem_we never asserted, memory unchanged.
- Assert reset during the WRITE cycle of a byte store -> mem_we falls at once, target word unchanged, req_ready 1, no resp_valid. A request held on req_valid during a busy state is accepted only after returning to IDLE.
